// File: rtl/saber_pkg.sv
// Shared definitions for the result readout block: default widths, the
// readout FSM state encoding and the read-issue flow-control rule.
package saber_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_LEN_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A new read may be issued only if every word already committed (held in
    // the FIFO, on the RAM output, or requested last cycle) plus the new one
    // still fits in the 2-entry FIFO when the consumer stops taking data.
    function automatic logic can_issue(
        input logic [1:0] occupancy,
        input logic       rd_p0,
        input logic       vld_p1,
        input logic       pop
    );
        logic [2:0] load;
        load = 3'(occupancy) + 3'(rd_p0) + 3'(vld_p1) - 3'(pop);
        return (load <= 3'd1);
    endfunction

endpackage

// File: rtl/result_readout_if.sv
// Valid/ready output stream of the result readout block.
interface result_readout_if
    import saber_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );

endinterface

// File: rtl/readout_fifo2.sv
// Two-entry FIFO; slot0 is the head register that drives the stream
// directly, so the output is stable while it is not popped.
module readout_fifo2
    import saber_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic [1:0]        cnt;

    // Storage and occupancy update; a pop on empty or a push on full without
    // a pop is ignored so the entries can never be corrupted.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            cnt   <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= push_data;
                        cnt   <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        slot1 <= push_data;
                        cnt   <= 2'd2;
                    end
                end
                2'b01: begin
                    if (cnt != 2'd0) begin
                        slot0 <= slot1;
                        cnt   <= cnt - 2'd1;
                    end
                end
                2'b11: begin
                    if (cnt == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                        cnt   <= 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = slot0;
    assign count = cnt;

endmodule

// File: rtl/result_readout.sv
// Reads num_words consecutive RAM words starting at base_addr and streams
// them out in address order through a 2-entry FIFO with valid/ready flow
// control. The RAM has a fixed one-cycle read latency.
module result_readout
    import saber_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              done,
    result_readout_if.master  strm
);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_cnt_nxt;
    logic [ADDR_W-1:0] issue_addr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  remaining_nxt;
    logic              issue;
    logic              vld_p1;
    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_valid;
    logic              pop;

    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid & strm.dout_ready;

    // Next-state, read-issue and address/length bookkeeping.
    always_comb begin
        state_nxt     = state;
        issue         = 1'b0;
        issue_addr    = addr_cnt;
        addr_cnt_nxt  = addr_cnt;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_nxt = DONE;
                    end else begin
                        // First read goes out on the same edge the command is taken.
                        issue         = 1'b1;
                        issue_addr    = base_addr;
                        addr_cnt_nxt  = base_addr + 1'b1;
                        remaining_nxt = num_words - 1'b1;
                        state_nxt     = (num_words == LEN_W'(1)) ? DRAIN : READ;
                    end
                end
            end
            READ: begin
                if (can_issue(fifo_count, mem_rd_en, vld_p1, pop)) begin
                    issue         = 1'b1;
                    issue_addr    = addr_cnt;
                    addr_cnt_nxt  = addr_cnt + 1'b1;
                    remaining_nxt = remaining - 1'b1;
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!mem_rd_en && !vld_p1 && (fifo_count == 2'd0)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p0: FSM state, address counter and the registered RAM request.
    // Stage p1: read data valid on mem_dout, pushed into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_cnt  <= addr_cnt_nxt;
            remaining <= remaining_nxt;
            mem_rd_en <= issue;
            vld_p1    <= mem_rd_en;
            if (issue) begin
                mem_addr <= issue_addr;
            end
        end
    end

    readout_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_p1),
        .push_data (mem_dout),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign strm.dout       = fifo_head;
    assign strm.dout_valid = fifo_valid;
    assign done            = (state == DONE);

endmodule

// File: tb/tb_result_readout.sv
// Scoreboard bench for result_readout: a behavioural one-cycle-latency RAM,
// directed commands that queue their expected words, and a monitor that pops
// and compares on every stream transfer.
module tb_result_readout;
    import saber_pkg::*;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 9;
    localparam int LEN_W  = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_words;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_dout;
    logic              done;

    result_readout_if #(.DATA_W(DATA_W)) strm ();

    result_readout #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_dout  (mem_dout),
        .done      (done),
        .strm      (strm)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram [512];
    always @(posedge clk) begin
        if (mem_rd_en) mem_dout <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int          addr_log[$];
    int          ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ready driver: always 1, or the repeating 1,0,0,1 pattern.
    initial begin
        logic [3:0] pat;
        int         ph;
        pat = 4'b1001;
        ph  = 0;
        strm.dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                strm.dout_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                strm.dout_ready = 1'b1;
            end
        end
    end

    // Monitor: compares every transfer against the scoreboard and checks
    // that a stalled word stays put.
    initial begin
        logic        hold_pend;
        logic [63:0] hold_data;
        hold_pend = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", 64'(strm.dout_valid), 64'd1);
                    check("hold_data", strm.dout, hold_data);
                end
                if (strm.dout_valid && strm.dout_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %h expected no word", strm.dout);
                    end else begin
                        check("word", strm.dout, exp_q.pop_front());
                    end
                end
                hold_pend = strm.dout_valid && !strm.dout_ready;
                hold_data = strm.dout;
            end
        end
    end

    // Issue one command (start held high) and watch until done or budget.
    task automatic run_cmd(input int base, input int len, input int alt_base, input int max_cyc,
                           output int rd_lat, output int vld_lat, output int done_lat,
                           output int n_rd, output bit timed_out);
        int t0;
        for (int k = 0; k < len; k++) exp_q.push_back(ram[(base + k) % 512]);
        addr_log.delete();
        base_addr = ADDR_W'(base);
        num_words = LEN_W'(len);
        start     = 1'b1;
        t0        = cyc + 1;
        rd_lat    = -1;
        vld_lat   = -1;
        done_lat  = -1;
        n_rd      = 0;
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (i == 2 && alt_base >= 0) base_addr = ADDR_W'(alt_base);
            if (mem_rd_en) begin
                addr_log.push_back(int'(mem_addr));
                n_rd++;
                if (rd_lat < 0) rd_lat = cyc - t0 + 1;
            end
            if (strm.dout_valid && vld_lat < 0) vld_lat = cyc - t0 + 1;
            if (done) begin
                done_lat  = cyc - t0 + 1;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic finish_cmd(input string tag, input bit timed_out);
        check({tag, "_timeout"}, 64'(timed_out), 64'd0);
        check({tag, "_all_words"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd1);
        start = 1'b0;
        @(negedge clk);
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_rd_en"}, 64'(mem_rd_en), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_dout_valid"}, 64'(strm.dout_valid), 64'd0);
        check({tag, "_dout"}, strm.dout, 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd_lat, vld_lat, done_lat, n_rd, n_vld, seen;
        bit to;

        ram[0] = 64'he0ea0043eafd6acb;
        for (int i = 1; i < 512; i++) ram[i] = ram[i-1] * 64'h5851f42d4c957f2d + 64'h14057b7ef767814f;

        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 120 words from address 0 with ready held high.
        ready_mode = 0;
        run_cmd(0, 120, -1, 2000, rd_lat, vld_lat, done_lat, n_rd, to);
        check("full_rd_latency", 64'(rd_lat), 64'd1);
        check("full_vld_latency", 64'(vld_lat), 64'd3);
        check("full_read_count", 64'(n_rd), 64'd120);
        check("full_first_addr", 64'(addr_log[0]), 64'd0);
        check("full_last_addr", 64'(addr_log[119]), 64'd119);
        finish_cmd("full", to);

        // 16 words with ready toggling 1,0,0,1.
        ready_mode = 1;
        run_cmd(120, 16, -1, 2000, rd_lat, vld_lat, done_lat, n_rd, to);
        check("toggle_read_count", 64'(n_rd), 64'd16);
        finish_cmd("toggle", to);
        ready_mode = 0;

        // Address wrap 510, 511, 0, 1.
        run_cmd(510, 4, -1, 500, rd_lat, vld_lat, done_lat, n_rd, to);
        check("wrap_read_count", 64'(n_rd), 64'd4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
            check("wrap_addr", 64'(addr_log[k]), 64'((510 + k) % 512));
        finish_cmd("wrap", to);

        // Zero-length command: no reads, done on the edge after start.
        run_cmd(5, 0, -1, 50, rd_lat, vld_lat, done_lat, n_rd, to);
        check("zero_done_latency", 64'(done_lat), 64'd1);
        check("zero_read_count", 64'(n_rd), 64'd0);
        @(negedge clk);
        check("zero_done_held", 64'(done), 64'd1);
        finish_cmd("zero", to);

        // Reset after 5 of 16 words.
        for (int k = 0; k < 16; k++) exp_q.push_back(ram[200 + k]);
        base_addr = ADDR_W'(200);
        num_words = LEN_W'(16);
        start     = 1'b1;
        seen      = 0;
        for (int i = 0; i < 400 && seen < 5; i++) begin
            @(negedge clk);
            if (strm.dout_valid && strm.dout_ready) seen++;
        end
        check("mid_rst_words_before", 64'(seen), 64'd5);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("mid_rst");
        n_vld = 0; n_rd = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (strm.dout_valid) n_vld++;
            if (mem_rd_en) n_rd++;
        end
        check("mid_rst_no_valid", 64'(n_vld), 64'd0);
        check("mid_rst_no_read", 64'(n_rd), 64'd0);
        @(posedge clk); #1;
        run_cmd(136, 4, -1, 500, rd_lat, vld_lat, done_lat, n_rd, to);
        check("after_rst_read_count", 64'(n_rd), 64'd4);
        finish_cmd("after_rst", to);

        // base_addr changed during READ must not affect the transfer.
        run_cmd(0, 8, 300, 500, rd_lat, vld_lat, done_lat, n_rd, to);
        check("base_change_read_count", 64'(n_rd), 64'd8);
        for (int k = 0; k < 8 && k < addr_log.size(); k++)
            check("base_change_addr", 64'(addr_log[k]), 64'(k));
        finish_cmd("base_change", to);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
